// File: rtl/zeroriscy_defines.sv
// Shared operator encodings and FSM state type for the zero-riscy multiply/divide unit.
package zeroriscy_defines;

    localparam logic [1:0] MD_OP_MULL = 2'b00;
    localparam logic [1:0] MD_OP_MULH = 2'b01;
    localparam logic [1:0] MD_OP_DIV  = 2'b10;
    localparam logic [1:0] MD_OP_REM  = 2'b11;

    typedef enum logic [2:0] {
        MD_IDLE     = 3'd0,
        MD_MUL      = 3'd1,
        MD_DIV_ABS  = 3'd2,
        MD_DIV_COMP = 3'd3,
        MD_DIV_SIGN = 3'd4,
        MD_DONE     = 3'd5
    } md_state_e;

endpackage

// File: rtl/zeroriscy_mac_kernel.sv
// Combinational signed (KWIDTH+1)x(KWIDTH+1) multiply whose product is shifted
// by idx_sum_i chunks and added into a 2*WIDTH accumulator.
module zeroriscy_mac_kernel #(
    parameter int WIDTH  = 32,
    parameter int KWIDTH = 16,
    parameter int IW     = 2
) (
    input  logic [KWIDTH-1:0]  a_chunk_i,
    input  logic               a_sign_i,
    input  logic [KWIDTH-1:0]  b_chunk_i,
    input  logic               b_sign_i,
    input  logic [IW-1:0]      idx_sum_i,
    input  logic [2*WIDTH-1:0] acc_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic signed [KWIDTH:0]     a_s;
    logic signed [KWIDTH:0]     b_s;
    logic signed [2*KWIDTH+1:0] prod_s;
    logic [2*WIDTH-1:0]         prod_ext_s;

    // Sign-extend the kernel product to accumulator width, then align and add
    always_comb begin
        a_s        = {a_sign_i, a_chunk_i};
        b_s        = {b_sign_i, b_chunk_i};
        prod_s     = (2*KWIDTH+2)'(a_s) * (2*KWIDTH+2)'(b_s);
        prod_ext_s = (2*WIDTH)'(prod_s);
        acc_o      = acc_i + (prod_ext_s << (int'(idx_sum_i) * KWIDTH));
    end

endmodule

// File: rtl/zeroriscy_multdiv_param.sv
// RV32M-style multiply/divide unit: chunked MAC multiplier plus private restoring divider.
// Define ZERORISCY_MULTDIV_DIV_EN to build the divider; otherwise DIV/REM complete at once with 0.
module zeroriscy_multdiv_param
    import zeroriscy_defines::*;
#(
    parameter int WIDTH  = 32,
    parameter int KWIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [1:0]       operator_i,
    input  logic [1:0]       signed_mode_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             kill_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o
);

    localparam int N  = WIDTH / KWIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    md_state_e            state_q, state_d, state_nxt;
    logic [1:0]           operator_q, operator_d;
    logic [1:0]           smode_q, smode_d;
    logic [WIDTH-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
    logic [CW-1:0]        idx_i_q, idx_i_d, idx_j_q, idx_j_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d, mac_acc;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 j_last;

`ifdef ZERORISCY_MULTDIV_DIV_EN
    localparam int DCW = $clog2(WIDTH);

    logic [WIDTH:0]       rem_q, rem_d, rem_sh;
    logic [WIDTH-1:0]     quot_q, quot_d, dvsr_q, dvsr_d;
    logic [DCW-1:0]       cnt_q, cnt_d;
    logic                 sign_a, sign_b;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1'b1)) : v;
    endfunction
`endif

    zeroriscy_mac_kernel #(
        .WIDTH  (WIDTH),
        .KWIDTH (KWIDTH),
        .IW     (CW + 1)
    ) u_mac (
        .a_chunk_i (op_a_q[int'(idx_i_q)*KWIDTH +: KWIDTH]),
        .a_sign_i  ((idx_i_q == CW'(N-1)) & smode_q[0] & op_a_q[WIDTH-1]),
        .b_chunk_i (op_b_q[int'(idx_j_q)*KWIDTH +: KWIDTH]),
        .b_sign_i  ((idx_j_q == CW'(N-1)) & smode_q[1] & op_b_q[WIDTH-1]),
        .idx_sum_i ({1'b0, idx_i_q} + {1'b0, idx_j_q}),
        .acc_i     (acc_q),
        .acc_o     (mac_acc)
    );

    // Next-state and datapath update; kill overrides any busy state
    always_comb begin
        state_nxt  = state_q;
        operator_d = operator_q;
        smode_d    = smode_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        idx_i_d    = idx_i_q;
        idx_j_d    = idx_j_q;
        acc_d      = acc_q;
        result_d   = result_q;
        // MULL stops each row at the last pair with i+j < N
        j_last     = (operator_q == MD_OP_MULH) ? (idx_j_q == CW'(N-1))
                                                : (idx_j_q == CW'(N-1) - idx_i_q);
`ifdef ZERORISCY_MULTDIV_DIV_EN
        rem_d      = rem_q;
        quot_d     = quot_q;
        dvsr_d     = dvsr_q;
        cnt_d      = cnt_q;
        sign_a     = smode_q[0] & op_a_q[WIDTH-1];
        sign_b     = smode_q[1] & op_b_q[WIDTH-1];
        rem_sh     = {rem_q[WIDTH-1:0], quot_q[WIDTH-1]};
`endif
        case (state_q)
            MD_IDLE: begin
                if (valid_i) begin
                    operator_d = operator_i;
                    smode_d    = signed_mode_i;
                    op_a_d     = op_a_i;
                    op_b_d     = op_b_i;
                    idx_i_d    = '0;
                    idx_j_d    = '0;
                    acc_d      = '0;
                    if ((operator_i == MD_OP_MULL) || (operator_i == MD_OP_MULH)) begin
                        state_nxt = MD_MUL;
`ifdef ZERORISCY_MULTDIV_DIV_EN
                    end else if (op_b_i == '0) begin
                        state_nxt = MD_DONE;
                        result_d  = (operator_i == MD_OP_DIV) ? '1 : op_a_i;
                    end else begin
                        state_nxt = MD_DIV_ABS;
                    end
`else
                    end else begin
                        state_nxt = MD_DONE;
                        result_d  = '0;
                    end
`endif
                end else begin
                    state_nxt = MD_IDLE;
                end
            end
            MD_MUL: begin
                acc_d = mac_acc;
                if (j_last && (idx_i_q == CW'(N-1))) begin
                    state_nxt = MD_DONE;
                    result_d  = (operator_q == MD_OP_MULH) ? mac_acc[2*WIDTH-1:WIDTH]
                                                           : mac_acc[WIDTH-1:0];
                end else if (j_last) begin
                    idx_i_d = idx_i_q + CW'(1'b1);
                    idx_j_d = '0;
                end else begin
                    idx_j_d = idx_j_q + CW'(1'b1);
                end
            end
`ifdef ZERORISCY_MULTDIV_DIV_EN
            MD_DIV_ABS: begin
                quot_d    = cond_neg(op_a_q, sign_a);
                dvsr_d    = cond_neg(op_b_q, sign_b);
                rem_d     = '0;
                cnt_d     = '0;
                state_nxt = MD_DIV_COMP;
            end
            MD_DIV_COMP: begin
                if (rem_sh >= {1'b0, dvsr_q}) begin
                    rem_d  = rem_sh - {1'b0, dvsr_q};
                    quot_d = {quot_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d  = rem_sh;
                    quot_d = {quot_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + DCW'(1'b1);
                if (cnt_q == DCW'(WIDTH-1)) begin
                    state_nxt = MD_DIV_SIGN;
                end else begin
                    state_nxt = MD_DIV_COMP;
                end
            end
            MD_DIV_SIGN: begin
                result_d  = (operator_q == MD_OP_DIV) ? cond_neg(quot_q, sign_a ^ sign_b)
                                                      : cond_neg(rem_q[WIDTH-1:0], sign_a);
                state_nxt = MD_DONE;
            end
`endif
            MD_DONE: begin
                if (ready_i) begin
                    state_nxt = MD_IDLE;
                end else begin
                    state_nxt = MD_DONE;
                end
            end
            default: begin
                state_nxt = MD_IDLE;
            end
        endcase
        state_d = (kill_i && (state_q != MD_IDLE)) ? MD_IDLE : state_nxt;
    end

    // Control and multiplier registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MD_IDLE;
            operator_q <= 2'b00;
            smode_q    <= 2'b00;
            op_a_q     <= '0;
            op_b_q     <= '0;
            idx_i_q    <= '0;
            idx_j_q    <= '0;
            acc_q      <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            operator_q <= operator_d;
            smode_q    <= smode_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            idx_i_q    <= idx_i_d;
            idx_j_q    <= idx_j_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
        end
    end

`ifdef ZERORISCY_MULTDIV_DIV_EN
    // Divider registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
        end else begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            dvsr_q <= dvsr_d;
            cnt_q  <= cnt_d;
        end
    end
`endif

    assign ready_o  = (state_q == MD_IDLE);
    assign valid_o  = (state_q == MD_DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_zeroriscy_multdiv_param.sv
// Self-checking bench for zeroriscy_multdiv_param: directed vector table, corner
// sequences (backpressure, kill, reset) and random operations against a plain-arithmetic model.
module tb_zeroriscy_multdiv_param;
    import zeroriscy_defines::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [1:0]  operator_i;
    logic [1:0]  signed_mode_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        kill_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[14];

`ifdef ZERORISCY_MULTDIV_DIV_EN
    localparam logic [1:0] KILL_OP = MD_OP_DIV;
    localparam int         KILL_AT = 10;
`else
    localparam logic [1:0] KILL_OP = MD_OP_MULH;
    localparam int         KILL_AT = 2;
`endif

    zeroriscy_multdiv_param #(.WIDTH(32), .KWIDTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .operator_i    (operator_i),
        .signed_mode_i (signed_mode_i),
        .op_a_i        (op_a_i),
        .op_b_i        (op_b_i),
        .kill_i        (kill_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .result_o      (result_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: exact products of sign/zero-extended operands, truncating division.
    function automatic logic [31:0] model_res(input logic [1:0] op, input logic [1:0] mode,
                                              input logic [31:0] a, input logic [31:0] b);
        logic signed [65:0] pa, pb, p;
        logic signed [32:0] da, db, q;
        pa = {{34{mode[0] & a[31]}}, a};
        pb = {{34{mode[1] & b[31]}}, b};
        p  = pa * pb;
        da = {mode[0] & a[31], a};
        db = {mode[1] & b[31], b};
        if (op == MD_OP_MULL) return p[31:0];
        if (op == MD_OP_MULH) return p[63:32];
`ifdef ZERORISCY_MULTDIV_DIV_EN
        if (b == 32'h0) return (op == MD_OP_DIV) ? 32'hFFFF_FFFF : a;
        q = (op == MD_OP_DIV) ? (da / db) : (da % db);
        return q[31:0];
`else
        q = da ^ db;
        return (q == 33'h0) ? 32'h0 : 32'h0;
`endif
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [31:0] b);
        if (op == MD_OP_MULL) return 4;
        if (op == MD_OP_MULH) return 5;
`ifdef ZERORISCY_MULTDIV_DIV_EN
        return (b == 32'h0) ? 1 : 35;
`else
        return (b == 32'h0) ? 1 : 1;
`endif
    endfunction

    task automatic issue(input logic [1:0] op, input logic [1:0] mode,
                         input logic [31:0] a, input logic [31:0] b, input string name);
        @(negedge clk);
        check({name, " ready_o idle"}, {31'h0, ready_o}, 32'h1);
        valid_i = 1'b1; operator_i = op; signed_mode_i = mode; op_a_i = a; op_b_i = b;
        @(negedge clk);
        valid_i = 1'b0; op_a_i = $urandom(); op_b_i = $urandom();
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!valid_o && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_result(input string name);
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        check({name, " ready_o after handshake"}, {31'h0, ready_o}, 32'h1);
        check({name, " valid_o after handshake"}, {31'h0, valid_o}, 32'h0);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [1:0] mode,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat, input string name);
        int lat;
        issue(op, mode, a, b, name);
        wait_valid(lat);
        check({name, " valid_o"}, {31'h0, valid_o}, 32'h1);
        check({name, " latency"}, lat, exp_lat);
        check({name, " result"}, result_o, exp_res);
        release_result(name);
    endtask

    initial begin
        int lat;
        int seen;
        logic [31:0] held;
        logic [31:0] ra, rb;
        logic [1:0]  rop, rmode;

        vecs[0]  = '{MD_OP_MULL, 2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 4};
        vecs[1]  = '{MD_OP_MULH, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 5};
        vecs[2]  = '{MD_OP_MULH, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5};
        vecs[3]  = '{MD_OP_MULH, 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 5};
        vecs[4]  = '{MD_OP_MULL, 2'b11, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 4};
        vecs[5]  = '{MD_OP_DIV,  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 35};
        vecs[6]  = '{MD_OP_REM,  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 35};
        vecs[7]  = '{MD_OP_DIV,  2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 35};
        vecs[8]  = '{MD_OP_REM,  2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 35};
        vecs[9]  = '{MD_OP_DIV,  2'b00, 32'd123,       32'h0000_0000, 32'hFFFF_FFFF, 1};
        vecs[10] = '{MD_OP_REM,  2'b00, 32'd123,       32'h0000_0000, 32'd123,       1};
        vecs[11] = '{MD_OP_DIV,  2'b00, 32'd100,       32'd7,         32'd14,        35};
        vecs[12] = '{MD_OP_REM,  2'b00, 32'd100,       32'd7,         32'd2,         35};
        vecs[13] = '{MD_OP_REM,  2'b11, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 1};

        rst = 1'b1; valid_i = 1'b0; operator_i = 2'b00; signed_mode_i = 2'b00;
        op_a_i = 32'h0; op_b_i = 32'h0; kill_i = 1'b0; ready_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset ready_o", {31'h0, ready_o}, 32'h1);
        check("reset valid_o", {31'h0, valid_o}, 32'h0);
        check("reset result_o", result_o, 32'h0);

        for (int i = 0; i < 14; i++) begin
            vec_t v;
            v = vecs[i];
`ifndef ZERORISCY_MULTDIV_DIV_EN
            if (v.op[1]) begin
                v.res = 32'h0;
                v.lat = 1;
            end
`endif
            run_op(v.op, v.mode, v.a, v.b, v.res, v.lat, $sformatf("vec%0d", i));
        end

        // Backpressure: result held, ready_o low, new requests ignored
        issue(MD_OP_MULL, 2'b00, 32'h0001_0003, 32'h0002_0005, "bp");
        wait_valid(lat);
        check("bp valid_o", {31'h0, valid_o}, 32'h1);
        held = result_o;
        check("bp result", held, 32'h000B_000F);
        valid_i = 1'b1; operator_i = MD_OP_MULH; op_a_i = 32'h1234_5678; op_b_i = 32'h9ABC_DEF0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp result stable", result_o, held);
            check("bp ready_o low", {31'h0, ready_o}, 32'h0);
            check("bp valid_o held", {31'h0, valid_o}, 32'h1);
        end
        valid_i = 1'b0;
        release_result("bp");
        @(negedge clk);
        check("bp no spurious valid", {31'h0, valid_o}, 32'h0);

        // Kill mid-operation: no result, unit usable afterwards
        issue(KILL_OP, 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, "kill");
        repeat (KILL_AT - 1) @(negedge clk);
        kill_i = 1'b1;
        @(negedge clk);
        kill_i = 1'b0;
        check("kill ready_o", {31'h0, ready_o}, 32'h1);
        check("kill valid_o", {31'h0, valid_o}, 32'h0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid_o) seen++;
        end
        check("kill valid never", seen, 0);
        run_op(MD_OP_MULL, 2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 4, "post-kill");

        // Reset mid-operation together with kill
        issue(KILL_OP, 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, "rst");
        repeat (KILL_AT - 1) @(negedge clk);
        rst = 1'b1; kill_i = 1'b1; ready_i = 1'b1;
        @(negedge clk);
        rst = 1'b0; kill_i = 1'b0; ready_i = 1'b0;
        check("midrst ready_o", {31'h0, ready_o}, 32'h1);
        check("midrst valid_o", {31'h0, valid_o}, 32'h0);
        check("midrst result_o", result_o, 32'h0);

        // Random operations against the arithmetic model
        for (int k = 0; k < 60; k++) begin
            rop   = 2'($urandom_range(0, 3));
            rmode = 2'($urandom_range(0, 3));
            ra    = $urandom();
            rb    = $urandom();
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 20));
                default: ;
            endcase
            run_op(rop, rmode, ra, rb, model_res(rop, rmode, ra, rb), model_lat(rop, rb),
                   $sformatf("rnd%0d op%0d m%0d a=%h b=%h", k, rop, rmode, ra, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
